adpcm_channel_sequencer: RTL and testbench

- Upstream control stage for ics_adpcm. Turns per-channel key-on/key-off pulses into the ordered channel-register write bursts and global start/stop writes that ics_adpcm expects.
- Requests a pitch from pitch_adjuster before each burst. Fetches sample attributes through a combinational lookup port.
- Replaces ad-hoc sequencing logic in top-level designs with one verified block.

---
 rtl/adpcm_pkg.sv | 34 +++
 rtl/adpcm_gb_arbiter.sv | 82 ++++++++
 rtl/adpcm_channel_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_adpcm_channel_sequencer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adpcm_pkg.sv
// Shared constants and types for the ics_adpcm control path: channel register
// indices, global write addresses and the channel sequencer state encoding.
package adpcm_pkg;

    localparam logic [2:0] REG_START   = 3'd0;
    localparam logic [2:0] REG_FLAGS   = 3'd1;
    localparam logic [2:0] REG_END     = 3'd2;
    localparam logic [2:0] REG_LOOP    = 3'd3;
    localparam logic [2:0] REG_VOLUMES = 3'd4;
    localparam logic [2:0] REG_PITCH   = 3'd5;
    localparam logic [2:0] REG_COUNT   = 3'd6;

    localparam logic GB_ADDR_START = 1'b0;
    localparam logic GB_ADDR_STOP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PITCH = 3'd1,
        ST_WRITE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [2:0] lowest_index(input logic [7:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/adpcm_gb_arbiter.sv
// Start/stop mask accumulators and the global write handshake toward ics_adpcm.
// Start masks always win over stop masks when both are waiting.
module adpcm_gb_arbiter
    import adpcm_pkg::*;
#(
    parameter int CHANNELS = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [CHANNELS-1:0] start_set_i,
    input  logic [CHANNELS-1:0] start_clr_i,
    input  logic [CHANNELS-1:0] stop_set_i,
    input  logic                gb_write_busy_i,
    input  logic                gb_write_ready_i,
    output logic                gb_write_address_o,
    output logic [CHANNELS-1:0] gb_write_data_o,
    output logic                gb_write_en_o,
    output logic [CHANNELS-1:0] pending_start_o,
    output logic [CHANNELS-1:0] pending_stop_o
);

    logic [CHANNELS-1:0] pending_start_q, pending_start_d;
    logic [CHANNELS-1:0] pending_stop_q, pending_stop_d;
    logic [CHANNELS-1:0] data_q, data_d;
    logic                addr_q, addr_d;
    logic                en_q, en_d;
    logic                issue;

    // Handshake: en rises with address/data stable and stays high until the
    // edge at which ready is sampled high; a new write never overlaps busy.
    always_comb begin
        pending_start_d = pending_start_q;
        pending_stop_d  = pending_stop_q;
        data_d          = data_q;
        addr_d          = addr_q;
        en_d            = en_q;
        issue           = !en_q && !gb_write_busy_i &&
                          ((|pending_start_q) || (|pending_stop_q));

        if (issue) begin
            en_d = 1'b1;
            if (|pending_start_q) begin
                addr_d          = GB_ADDR_START;
                data_d          = pending_start_q;
                pending_start_d = '0;
            end else begin
                addr_d         = GB_ADDR_STOP;
                data_d         = pending_stop_q;
                pending_stop_d = '0;
            end
        end else if (en_q && gb_write_ready_i) begin
            en_d = 1'b0;
        end

        // Bits arriving this cycle survive the clear and go out next time.
        pending_start_d = (pending_start_d | start_set_i) & ~start_clr_i;
        pending_stop_d  = pending_stop_d | stop_set_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_start_q <= '0;
            pending_stop_q  <= '0;
            data_q          <= '0;
            addr_q          <= 1'b0;
            en_q            <= 1'b0;
        end else begin
            pending_start_q <= pending_start_d;
            pending_stop_q  <= pending_stop_d;
            data_q          <= data_d;
            addr_q          <= addr_d;
            en_q            <= en_d;
        end
    end

    assign gb_write_address_o = addr_q;
    assign gb_write_data_o    = data_q;
    assign gb_write_en_o      = en_q;
    assign pending_start_o    = pending_start_q;
    assign pending_stop_o     = pending_stop_q;

endmodule

// File: rtl/adpcm_channel_sequencer.sv
// Turns per-channel key-on/key-off pulses into ordered six-register channel
// bursts for ics_adpcm, followed by global start/stop mask writes.
module adpcm_channel_sequencer
    import adpcm_pkg::*;
#(
    parameter int CHANNELS    = 3,
    parameter int ADDR_STRIDE = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] key_on,
    input  logic [CHANNELS-1:0] key_off,
    output logic [2:0]          cfg_channel,
    input  logic [15:0]         cfg_start,
    input  logic [15:0]         cfg_end,
    input  logic [15:0]         cfg_loop,
    input  logic                cfg_looped,
    input  logic [15:0]         cfg_volumes,
    output logic                pitch_request,
    input  logic [15:0]         pitch_in,
    input  logic                pitch_valid,
    output logic [7:0]          ch_write_address,
    output logic [15:0]         ch_write_data,
    output logic                ch_write_en,
    input  logic                ch_write_ready,
    output logic                gb_write_address,
    output logic [CHANNELS-1:0] gb_write_data,
    output logic                gb_write_en,
    input  logic                gb_write_busy,
    input  logic                gb_write_ready,
    output logic                busy
);

    logic [1:0]          rst_sync_q;
    logic                rst_n_int;
    seq_state_e          state_q;
    logic [2:0]          cfg_channel_q;
    logic [2:0]          reg_index_q;
    logic                pitch_request_q;
    logic [15:0]         pitch_q;
    logic                ch_en_q;
    logic [7:0]          ch_addr_q;
    logic [15:0]         ch_data_q;
    logic [CHANNELS-1:0] pending_config_q, pending_config_d;
    logic [CHANNELS-1:0] abort_q, abort_d;
    logic                rekey_q, rekey_d;

    logic [CHANNELS-1:0] key_off_eff, ch_mask, flight_mask, cancel_mask, avail;
    logic [CHANNELS-1:0] start_set, pending_start, pending_stop;
    logic                in_flight, rekey_hit, abort_hit, abort_now;
    logic [2:0]          next_index;
    logic [7:0]          next_addr;
    logic [15:0]         next_data;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            ch_mask[i] = (cfg_channel_q == 3'(i));
        end
    end

    always_comb begin
        next_index = (state_q == ST_GAP) ? reg_index_q + 3'd1 : REG_START;
        next_addr  = 8'(int'(cfg_channel_q) * ADDR_STRIDE + int'(next_index));
        unique case (next_index)
            REG_START:   next_data = cfg_start;
            REG_FLAGS:   next_data = {15'b0, cfg_looped};
            REG_END:     next_data = cfg_end;
            REG_LOOP:    next_data = cfg_loop;
            REG_VOLUMES: next_data = cfg_volumes;
            default:     next_data = pitch_q;
        endcase
    end

    // A key_on that arrives while its own channel is in flight is remembered in
    // rekey_q so DONE leaves pending_config set and the burst runs again.
    always_comb begin
        key_off_eff      = key_off & ~key_on;
        in_flight        = (state_q != ST_IDLE);
        flight_mask      = in_flight ? ch_mask : '0;
        cancel_mask      = key_off_eff & pending_config_q & ~flight_mask;
        avail            = pending_config_q & ~cancel_mask;
        rekey_hit        = |(key_on & flight_mask);
        abort_hit        = |(key_off_eff & flight_mask);
        abort_now        = (|(abort_q & ch_mask)) || abort_hit;
        pending_config_d = pending_config_q & ~cancel_mask;
        abort_d          = abort_q | (key_off_eff & flight_mask);
        start_set        = '0;
        rekey_d          = rekey_q;
        if (rekey_hit)      rekey_d = 1'b1;
        else if (abort_hit) rekey_d = 1'b0;

        if (state_q == ST_DONE) begin
            if (!rekey_q || abort_hit) pending_config_d = pending_config_d & ~ch_mask;
            if (!abort_now)            start_set = ch_mask;
            abort_d = abort_d & ~ch_mask;
            rekey_d = 1'b0;
        end
        pending_config_d = pending_config_d | key_on;
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q          <= ST_IDLE;
            cfg_channel_q    <= 3'd0;
            reg_index_q      <= REG_START;
            pitch_request_q  <= 1'b0;
            pitch_q          <= 16'd0;
            ch_en_q          <= 1'b0;
            ch_addr_q        <= 8'd0;
            ch_data_q        <= 16'd0;
            pending_config_q <= '0;
            abort_q          <= '0;
            rekey_q          <= 1'b0;
        end else begin
            pending_config_q <= pending_config_d;
            abort_q          <= abort_d;
            rekey_q          <= rekey_d;
            pitch_request_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (|avail) begin
                        cfg_channel_q   <= lowest_index(8'(avail));
                        pitch_request_q <= 1'b1;
                        state_q         <= ST_PITCH;
                    end
                end
                ST_PITCH: begin
                    if (pitch_valid) begin
                        pitch_q     <= pitch_in;
                        reg_index_q <= REG_START;
                        ch_en_q     <= 1'b1;
                        ch_addr_q   <= next_addr;
                        ch_data_q   <= next_data;
                        state_q     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (ch_write_ready) begin
                        ch_en_q <= 1'b0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (reg_index_q == REG_COUNT - 3'd1) begin
                        state_q <= ST_DONE;
                    end else begin
                        reg_index_q <= next_index;
                        ch_en_q     <= 1'b1;
                        ch_addr_q   <= next_addr;
                        ch_data_q   <= next_data;
                        state_q     <= ST_WRITE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    adpcm_gb_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_gb_arbiter (
        .clk_i              (clk),
        .rst_ni             (rst_n_int),
        .start_set_i        (start_set),
        .start_clr_i        (cancel_mask),
        .stop_set_i         (key_off_eff),
        .gb_write_busy_i    (gb_write_busy),
        .gb_write_ready_i   (gb_write_ready),
        .gb_write_address_o (gb_write_address),
        .gb_write_data_o    (gb_write_data),
        .gb_write_en_o      (gb_write_en),
        .pending_start_o    (pending_start),
        .pending_stop_o     (pending_stop)
    );

    assign cfg_channel      = cfg_channel_q;
    assign pitch_request    = pitch_request_q;
    assign ch_write_address = ch_addr_q;
    assign ch_write_data    = ch_data_q;
    assign ch_write_en      = ch_en_q;
    assign busy             = in_flight || (|pending_config_q) || (|pending_start) ||
                              (|pending_stop) || gb_write_en;

endmodule

// File: tb/tb_adpcm_channel_sequencer.sv
// Directed bench for adpcm_channel_sequencer: attribute table, pitch and
// ready responders, captured write queues compared against expected queues.
module tb_adpcm_channel_sequencer;

    localparam int CHANNELS = 3;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [CHANNELS-1:0] key_on, key_off;
    logic [2:0]          cfg_channel;
    logic [15:0]         cfg_start, cfg_end, cfg_loop, cfg_volumes;
    logic                cfg_looped;
    logic                pitch_request;
    logic [15:0]         pitch_in = 16'd0;
    logic                pitch_valid = 1'b0;
    logic [7:0]          ch_write_address;
    logic [15:0]         ch_write_data;
    logic                ch_write_en;
    logic                ch_write_ready = 1'b0;
    logic                gb_write_address;
    logic [CHANNELS-1:0] gb_write_data;
    logic                gb_write_en;
    logic                gb_write_busy;
    logic                gb_write_ready = 1'b0;
    logic                busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] tbl_start[8], tbl_end[8], tbl_loop[8], tbl_vol[8], tbl_pitch[8];
    logic        tbl_looped[8];

    int pitch_delay = 3;
    int p_cnt = 0;
    bit p_pend = 0;
    int ch_delay[8];
    int ch_cnt = 0;
    int gb_cnt = 0;

    logic [23:0] got_ch_q[$];
    logic [23:0] exp_q[$];
    logic [3:0]  got_gb_q[$];
    logic [3:0]  exp_gb_q[$];

    adpcm_channel_sequencer #(.CHANNELS(CHANNELS), .ADDR_STRIDE(8)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .key_on           (key_on),
        .key_off          (key_off),
        .cfg_channel      (cfg_channel),
        .cfg_start        (cfg_start),
        .cfg_end          (cfg_end),
        .cfg_loop         (cfg_loop),
        .cfg_looped       (cfg_looped),
        .cfg_volumes      (cfg_volumes),
        .pitch_request    (pitch_request),
        .pitch_in         (pitch_in),
        .pitch_valid      (pitch_valid),
        .ch_write_address (ch_write_address),
        .ch_write_data    (ch_write_data),
        .ch_write_en      (ch_write_en),
        .ch_write_ready   (ch_write_ready),
        .gb_write_address (gb_write_address),
        .gb_write_data    (gb_write_data),
        .gb_write_en      (gb_write_en),
        .gb_write_busy    (gb_write_busy),
        .gb_write_ready   (gb_write_ready),
        .busy             (busy)
    );

    // Clock
    always #5 clk = ~clk;

    assign cfg_start   = tbl_start[cfg_channel];
    assign cfg_end     = tbl_end[cfg_channel];
    assign cfg_loop    = tbl_loop[cfg_channel];
    assign cfg_looped  = tbl_looped[cfg_channel];
    assign cfg_volumes = tbl_vol[cfg_channel];

    // Responders and write capture, all on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            pitch_valid    = 1'b0;
            p_pend         = 0;
            ch_write_ready = 1'b0;
            ch_cnt         = 0;
            gb_write_ready = 1'b0;
            gb_cnt         = 0;
        end else begin
            pitch_valid = 1'b0;
            if (p_pend) begin
                if (p_cnt <= 1) begin
                    pitch_valid = 1'b1;
                    pitch_in    = tbl_pitch[cfg_channel];
                    p_pend      = 0;
                end else begin
                    p_cnt--;
                end
            end
            if (pitch_request) begin
                p_pend = 1;
                p_cnt  = pitch_delay;
            end
            if (ch_write_en && !ch_write_ready) begin
                if (ch_cnt >= ch_delay[ch_write_address[2:0]]) begin
                    ch_write_ready = 1'b1;
                    ch_cnt         = 0;
                    got_ch_q.push_back({ch_write_address, ch_write_data});
                end else begin
                    ch_cnt++;
                end
            end else begin
                ch_write_ready = 1'b0;
                ch_cnt         = 0;
            end
            if (gb_write_en && !gb_write_ready) begin
                gb_write_ready = 1'b1;
                got_gb_q.push_back({gb_write_address, gb_write_data});
            end else begin
                gb_write_ready = 1'b0;
            end
        end
    end

    // Driver tasks
    task automatic pulse(input logic [CHANNELS-1:0] on, input logic [CHANNELS-1:0] off);
        key_on  = on;
        key_off = off;
        @(negedge clk);
        key_on  = '0;
        key_off = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", tag, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_queues();
        got_ch_q.delete();
        exp_q.delete();
        got_gb_q.delete();
        exp_gb_q.delete();
    endtask

    task automatic push_burst(input int ch);
        int base = ch * 8;
        exp_q.push_back({8'(base + 0), tbl_start[ch]});
        exp_q.push_back({8'(base + 1), 15'b0, tbl_looped[ch]});
        exp_q.push_back({8'(base + 2), tbl_end[ch]});
        exp_q.push_back({8'(base + 3), tbl_loop[ch]});
        exp_q.push_back({8'(base + 4), tbl_vol[ch]});
        exp_q.push_back({8'(base + 5), tbl_pitch[ch]});
    endtask

    task automatic test_reset();
        checks++;
        if (ch_write_en !== 1'b0) begin errors++; $display("FAIL reset_ch_en: got %b required 0", ch_write_en); end
        checks++;
        if (gb_write_en !== 1'b0) begin errors++; $display("FAIL reset_gb_en: got %b required 0", gb_write_en); end
        checks++;
        if (pitch_request !== 1'b0) begin errors++; $display("FAIL reset_pitch_req: got %b required 0", pitch_request); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++;
        if ({cfg_channel, ch_write_address, ch_write_data} !== 27'd0) begin
            errors++;
            $display("FAIL reset_ch_bus: got ch %0h addr %0h data %0h required 0", cfg_channel, ch_write_address, ch_write_data);
        end
        checks++;
        if ({gb_write_address, gb_write_data} !== 4'd0) begin
            errors++;
            $display("FAIL reset_gb_bus: got addr %0h data %0h required 0", gb_write_address, gb_write_data);
        end
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b required 0", busy); end
    endtask

    task automatic test_single();
        clear_queues();
        key_on = 3'b001;
        @(negedge clk);
        key_on = 3'b000;
        checks++;
        if (pitch_request !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b required 0", pitch_request); end
        @(negedge clk);
        checks++;
        if (pitch_request !== 1'b1) begin errors++; $display("FAIL single_req_latency: got %b required 1", pitch_request); end
        checks++;
        if (cfg_channel !== 3'd0) begin errors++; $display("FAIL single_cfg_channel: got %0d required 0", cfg_channel); end
        wait_idle("single");
        exp_q = '{24'h00_0000, 24'h01_0000, 24'h02_0018, 24'h03_FFFF, 24'h04_1010, 24'h05_0A14};
        exp_gb_q = '{4'b0_001};
        checks++;
        if (got_ch_q.size() != exp_q.size()) begin
            errors++; $display("FAIL single_ch_count: got %0d required %0d", got_ch_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_ch_q.size(); i++) begin
            checks++;
            if (got_ch_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL single_ch_write[%0d]: got %h required %h", i, got_ch_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_gb_q.size() != 1 || got_gb_q[0] !== exp_gb_q[0]) begin
            errors++; $display("FAIL single_gb_write: got %0d writes first %h required 1 write %h", got_gb_q.size(), (got_gb_q.size() > 0) ? got_gb_q[0] : 4'hx, exp_gb_q[0]);
        end
    endtask

    task automatic test_two_channels();
        clear_queues();
        pulse(3'b110, 3'b000);
        wait_idle("two_ch");
        push_burst(1);
        push_burst(2);
        exp_gb_q = '{4'b0_010, 4'b0_100};
        checks++;
        if (got_ch_q.size() != exp_q.size()) begin
            errors++; $display("FAIL two_ch_count: got %0d required %0d", got_ch_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_ch_q.size(); i++) begin
            checks++;
            if (got_ch_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL two_ch_write[%0d]: got %h required %h", i, got_ch_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_gb_q.size() != exp_gb_q.size()) begin
            errors++; $display("FAIL two_ch_gb_count: got %0d required %0d", got_gb_q.size(), exp_gb_q.size());
        end
        for (int i = 0; i < exp_gb_q.size() && i < got_gb_q.size(); i++) begin
            checks++;
            if (got_gb_q[i] !== exp_gb_q[i]) begin
                errors++; $display("FAIL two_ch_gb[%0d]: got %h required %h", i, got_gb_q[i], exp_gb_q[i]);
            end
        end
    endtask

    task automatic test_busy_merge();
        int n = 0;
        clear_queues();
        gb_write_busy = 1'b1;
        pulse(3'b110, 3'b000);
        while (got_ch_q.size() < 12 && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (got_ch_q.size() != 12) begin
            errors++; $display("FAIL merge_ch_count: got %0d required 12", got_ch_q.size());
        end
        repeat (6) @(negedge clk);
        checks++;
        if (gb_write_en !== 1'b0) begin errors++; $display("FAIL merge_gb_held: got en %b required 0", gb_write_en); end
        gb_write_busy = 1'b0;
        wait_idle("merge");
        checks++;
        if (got_gb_q.size() != 1 || got_gb_q[0] !== 4'b0_110) begin
            errors++; $display("FAIL merge_gb_write: got %0d writes first %h required 1 write 6", got_gb_q.size(), (got_gb_q.size() > 0) ? got_gb_q[0] : 4'hx);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        clear_queues();
        pulse(3'b001, 3'b000);
        while (!(ch_write_en && ch_write_address == 8'd2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(ch_write_en && ch_write_address == 8'd2)) begin
            errors++; $display("FAIL abort_find_end: got en %b addr %0h required en 1 addr 2", ch_write_en, ch_write_address);
        end
        pulse(3'b000, 3'b001);
        wait_idle("abort");
        push_burst(0);
        checks++;
        if (got_ch_q.size() != exp_q.size()) begin
            errors++; $display("FAIL abort_ch_count: got %0d required %0d", got_ch_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_ch_q.size(); i++) begin
            checks++;
            if (got_ch_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL abort_ch_write[%0d]: got %h required %h", i, got_ch_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_gb_q.size() != 1 || got_gb_q[0] !== 4'b1_001) begin
            errors++; $display("FAIL abort_gb_write: got %0d writes first %h required 1 write 9", got_gb_q.size(), (got_gb_q.size() > 0) ? got_gb_q[0] : 4'hx);
        end
    endtask

    task automatic test_ready_stall();
        int n = 0;
        int hi = 0;
        int lo = 0;
        clear_queues();
        ch_delay[3] = 5;
        pulse(3'b001, 3'b000);
        while (!(ch_write_en && ch_write_address == 8'd3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (ch_write_en && hi < 20) begin
            checks++;
            if (ch_write_address !== 8'd3 || ch_write_data !== 16'hFFFF) begin
                errors++; $display("FAIL stall_stable[%0d]: got addr %0h data %0h required addr 3 data ffff", hi, ch_write_address, ch_write_data);
            end
            hi++;
            @(negedge clk);
        end
        checks++;
        if (hi != 6) begin errors++; $display("FAIL stall_en_cycles: got %0d required 6", hi); end
        while (!ch_write_en && lo < 20) begin
            lo++;
            @(negedge clk);
        end
        checks++;
        if (lo != 1) begin errors++; $display("FAIL stall_gap_cycles: got %0d required 1", lo); end
        checks++;
        if (ch_write_address !== 8'd4 || ch_write_data !== 16'h1010) begin
            errors++; $display("FAIL stall_next_write: got addr %0h data %0h required addr 4 data 1010", ch_write_address, ch_write_data);
        end
        wait_idle("stall");
        ch_delay[3] = 0;
        checks++;
        if (got_ch_q.size() != 6) begin errors++; $display("FAIL stall_ch_count: got %0d required 6", got_ch_q.size()); end
    endtask

    task automatic test_on_off_same();
        clear_queues();
        pulse(3'b100, 3'b100);
        wait_idle("on_off");
        push_burst(2);
        checks++;
        if (got_ch_q.size() != exp_q.size()) begin
            errors++; $display("FAIL on_off_ch_count: got %0d required %0d", got_ch_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_ch_q.size(); i++) begin
            checks++;
            if (got_ch_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL on_off_ch_write[%0d]: got %h required %h", i, got_ch_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_gb_q.size() != 1 || got_gb_q[0] !== 4'b0_100) begin
            errors++; $display("FAIL on_off_gb_write: got %0d writes first %h required 1 write 4", got_gb_q.size(), (got_gb_q.size() > 0) ? got_gb_q[0] : 4'hx);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_queues();
        pitch_delay = 20;
        pulse(3'b010, 3'b000);
        while (!pitch_request && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pitch_request !== 1'b1 || cfg_channel !== 3'd1) begin
            errors++; $display("FAIL rst_mid_enter: got req %b ch %0d required req 1 ch 1", pitch_request, cfg_channel);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (pitch_request !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async: got req %b busy %b required 0 0", pitch_request, busy);
        end
        checks++;
        if (cfg_channel !== 3'd0 || ch_write_en !== 1'b0 || gb_write_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs: got ch %0d ch_en %b gb_en %b required 0 0 0", cfg_channel, ch_write_en, gb_write_en);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        pitch_delay = 3;
        repeat (40) @(negedge clk);
        checks++;
        if (got_ch_q.size() != 0 || got_gb_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_quiet: got %0d ch writes %0d gb writes busy %b required 0 0 0", got_ch_q.size(), got_gb_q.size(), busy);
        end
        pulse(3'b001, 3'b000);
        wait_idle("rst_recover");
        checks++;
        if (got_ch_q.size() != 6 || got_gb_q.size() != 1) begin
            errors++; $display("FAIL rst_mid_recover: got %0d ch writes %0d gb writes required 6 1", got_ch_q.size(), got_gb_q.size());
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        key_on        = '0;
        key_off       = '0;
        gb_write_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tbl_start[i] = 16'd0; tbl_end[i] = 16'd0; tbl_loop[i] = 16'd0;
            tbl_vol[i] = 16'd0; tbl_pitch[i] = 16'd0; tbl_looped[i] = 1'b0;
            ch_delay[i] = 0;
        end
        tbl_start[0] = 16'h0000; tbl_end[0] = 16'h0018; tbl_loop[0] = 16'hFFFF;
        tbl_looped[0] = 1'b0; tbl_vol[0] = 16'h1010; tbl_pitch[0] = 16'h0A14;
        tbl_start[1] = 16'h0100; tbl_end[1] = 16'h0118; tbl_loop[1] = 16'h0105;
        tbl_looped[1] = 1'b1; tbl_vol[1] = 16'h2020; tbl_pitch[1] = 16'h1111;
        tbl_start[2] = 16'h0200; tbl_end[2] = 16'h0230; tbl_loop[2] = 16'h0210;
        tbl_looped[2] = 1'b1; tbl_vol[2] = 16'h3030; tbl_pitch[2] = 16'h2222;
        repeat (3) @(negedge clk);

        test_reset();
        test_single();
        test_two_channels();
        test_busy_merge();
        test_abort();
        test_ready_stall();
        test_on_off_same();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
